node_loader: RTL and testbench
==============================

NODE_LOADER -- requirements
Module: node_loader

Interface
REQ-001 SHALL have parameter NODES_PER_FRAME, default 64, giving lattice nodes per frame (range 1..65535).
REQ-002 SHALL have port aclk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port aresetn, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port s_axis_tdata, input, 16, one Q3.13 population word.
REQ-005 SHALL have port s_axis_tvalid, input, 1, upstream word valid.
REQ-006 SHALL have port s_axis_tready, output, 1, block accepts word.
REQ-007 SHALL have port s_axis_tlast, input, 1, marks last word of frame.
REQ-008 SHALL have ports f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw, output, 16 each, assembled node populations to collider.
REQ-009 SHALL have port node_valid, output, 1, assembled node held stable on f_* outputs.
REQ-010 SHALL have port node_ready, input, 1, collider consumes node.
REQ-011 SHALL have port node_idx, output, 16, index within frame of node on f_* outputs.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse on handoff of last node of frame.
REQ-013 SHALL have port tlast_err, output, 1, sticky framing-error flag.

Function
REQ-014 SHALL have two states: FILL (s_axis_tready=1, node_valid=0) and HOLD (s_axis_tready=0, node_valid=1).
REQ-015 SHALL accept a word only on s_axis_tvalid && s_axis_tready in the same cycle; word counter 0..8 increments per accepted word.
REQ-016 SHALL map word counter 0..8 to f_null, f_n, f_ne, f_e, f_se, f_s, f_sw, f_w, f_nw in that order; data registered, no arithmetic or width change.
REQ-017 SHALL transition FILL->HOLD on acceptance of word 8; node_valid asserts the next cycle (1 cycle after 9th word).
REQ-018 SHALL hold f_* and node_idx stable throughout HOLD, independent of s_axis_* inputs.
REQ-019 SHALL transition HOLD->FILL on node_valid && node_ready; word counter to 0; node_idx increments, wrapping NODES_PER_FRAME-1 -> 0.
REQ-020 SHALL pulse frame_done for exactly the handoff cycle when node_idx == NODES_PER_FRAME-1.
REQ-021 SHALL treat tlast as expected only on word 8 of node NODES_PER_FRAME-1.
REQ-022 SHALL, on tlast accepted on any other word (early tlast), set tlast_err, discard partial node, reset word counter and node_idx to 0, stay in FILL, no node_valid, no frame_done.
REQ-023 SHALL, on word 8 of last node accepted with tlast=0 (missing tlast), set tlast_err and still hand off the node normally, with frame_done and node_idx wrap.
REQ-024 SHALL clear tlast_err only by reset.
REQ-025 SHALL never drop or duplicate an accepted word except as in REQ-022; no node_valid while in FILL.

Reset
REQ-026 SHALL, while aresetn=0, asynchronously force state FILL, word counter 0, node_idx 0, f_* 0, node_valid 0, frame_done 0, tlast_err 0, s_axis_tready 0.
REQ-027 SHALL drive s_axis_tready=1 from the first rising edge after aresetn deasserts.
REQ-028 SHALL, on reset mid-node or during HOLD, discard the pending node with no handoff.

Verification
REQ-029 Single node, NODES_PER_FRAME=1: words 0x0001..0x0009 back-to-back, tlast on 9th, node_ready=1 -> f_null=0x0001 ... f_nw=0x0009, node_valid 1 cycle after 9th accept, frame_done coincident with handoff, tlast_err=0.
REQ-030 Backpressure: node_ready=0 for 20 cycles after node_valid -> s_axis_tready=0 and f_* unchanged for all 20 cycles; handoff on cycle node_ready rises.
REQ-031 Valid gaps: s_axis_tvalid toggled 1/0 over 9 words -> same node contents as gapless case, counter advances only on handshake.
REQ-032 Early tlast, NODES_PER_FRAME=4: tlast on word 4 of node 0 -> tlast_err=1, no node_valid; next 36 words yield nodes 0..3, frame_done on node 3.
REQ-033 Missing tlast, NODES_PER_FRAME=2: 18 words, no tlast -> tlast_err=1, both nodes delivered, frame_done on node 1, node_idx returns to 0.
REQ-034 Reset during HOLD: aresetn low 1 cycle with node_valid=1 -> node_valid=0, f_*=0, node_idx=0 immediately; next 9 words form node 0.

Source files
------------

// File: rtl/node_loader.sv
// node_loader
// ---------------------------------------------------------------------------
// Collects nine consecutive 16-bit Q3.13 population words from an AXI-Stream
// source into one D2Q9 lattice node and offers it to the collider through a
// valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high.  Once a valid is raised it stays up, and its data stays stable,
// until that transfer.  Ready may be high or low independently of valid.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/     upstream word stream; tlast marks the last word
//   tready/tlast             of the last node of a frame
//   f_null .. f_nw           assembled node populations (held in HOLD)
//   node_valid, node_ready   node handshake to the collider
//   node_idx                 index within frame of the node on f_*
//   frame_done               pulse on handoff of the frame's last node
//   tlast_err                sticky framing-error flag (cleared by reset only)
//   dbg_state                current FSM state (0 = FILL, 1 = HOLD)
// ---------------------------------------------------------------------------
module node_loader #(
    parameter int NODES_PER_FRAME = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [15:0] f_null,
    output logic [15:0] f_n,
    output logic [15:0] f_ne,
    output logic [15:0] f_e,
    output logic [15:0] f_se,
    output logic [15:0] f_s,
    output logic [15:0] f_sw,
    output logic [15:0] f_w,
    output logic [15:0] f_nw,
    output logic        node_valid,
    input  logic        node_ready,
    output logic [15:0] node_idx,
    output logic        frame_done,
    output logic        tlast_err,
    output logic        dbg_state
);

    localparam logic [15:0] LAST_IDX  = 16'(NODES_PER_FRAME - 1);
    localparam logic [3:0]  LAST_WORD = 4'd8;

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] f_q [9];
    logic [15:0] f_d [9];
    logic        err_q, err_d;
    // Holds tready low until the first edge after reset is released.
    logic        ready_en_q;

    logic accept;
    logic last_node;
    logic last_word;

    assign s_axis_tready = ready_en_q && (state_q == S_FILL);
    assign node_valid    = (state_q == S_HOLD);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign last_node     = (idx_q == LAST_IDX);
    assign last_word     = (wcnt_q == LAST_WORD);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        frame_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            f_d[i] = f_q[i];
        end

        case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (s_axis_tlast && !(last_word && last_node)) begin
                        // Early tlast: drop the partial node and restart
                        // the frame from node 0.
                        err_d  = 1'b1;
                        wcnt_d = 4'd0;
                        idx_d  = 16'd0;
                    end else begin
                        for (int i = 0; i < 9; i++) begin
                            if (wcnt_q == 4'(i)) begin
                                f_d[i] = s_axis_tdata;
                            end
                        end
                        if (last_word) begin
                            state_d = S_HOLD;
                            wcnt_d  = 4'd0;
                            // Missing tlast: flag it but deliver the node.
                            if (last_node && !s_axis_tlast) begin
                                err_d = 1'b1;
                            end
                        end else begin
                            wcnt_d = wcnt_q + 4'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (node_ready) begin
                    state_d    = S_FILL;
                    frame_done = last_node;
                    idx_d      = last_node ? 16'd0 : idx_q + 16'd1;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_FILL;
            wcnt_q     <= 4'd0;
            idx_q      <= 16'd0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                f_q[i] <= 16'd0;
            end
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
            for (int i = 0; i < 9; i++) begin
                f_q[i] <= f_d[i];
            end
        end
    end

    assign f_null    = f_q[0];
    assign f_n       = f_q[1];
    assign f_ne      = f_q[2];
    assign f_e       = f_q[3];
    assign f_se      = f_q[4];
    assign f_s       = f_q[5];
    assign f_sw      = f_q[6];
    assign f_w       = f_q[7];
    assign f_nw      = f_q[8];
    assign node_idx  = idx_q;
    assign tlast_err = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_node_loader.sv
`timescale 1ns/1ps
module tb_node_loader;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn;
    logic [15:0] tdata;
    logic        tvalid_s;
    logic        tlast;
    logic        nready_s;
    logic [1:0]  sel;

    logic [2:0]  tready, nvalid, fdone, terr, dbg;
    logic [15:0] fo  [3][9];
    logic [15:0] idx [3];

    int total = 0;
    int bad   = 0;
    logic [160:0] exp_q[$];

    // Three DUTs with different frame sizes; only the selected one sees traffic.
    node_loader #(.NODES_PER_FRAME(1)) u_n1 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid_s && (sel == 2'd0)), .s_axis_tready(tready[0]),
        .s_axis_tlast(tlast),
        .f_null(fo[0][0]), .f_n(fo[0][1]), .f_ne(fo[0][2]), .f_e(fo[0][3]),
        .f_se(fo[0][4]), .f_s(fo[0][5]), .f_sw(fo[0][6]), .f_w(fo[0][7]),
        .f_nw(fo[0][8]), .node_valid(nvalid[0]),
        .node_ready(nready_s && (sel == 2'd0)), .node_idx(idx[0]),
        .frame_done(fdone[0]), .tlast_err(terr[0]), .dbg_state(dbg[0])
    );
    node_loader #(.NODES_PER_FRAME(4)) u_n4 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid_s && (sel == 2'd1)), .s_axis_tready(tready[1]),
        .s_axis_tlast(tlast),
        .f_null(fo[1][0]), .f_n(fo[1][1]), .f_ne(fo[1][2]), .f_e(fo[1][3]),
        .f_se(fo[1][4]), .f_s(fo[1][5]), .f_sw(fo[1][6]), .f_w(fo[1][7]),
        .f_nw(fo[1][8]), .node_valid(nvalid[1]),
        .node_ready(nready_s && (sel == 2'd1)), .node_idx(idx[1]),
        .frame_done(fdone[1]), .tlast_err(terr[1]), .dbg_state(dbg[1])
    );
    node_loader #(.NODES_PER_FRAME(2)) u_n2 (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata),
        .s_axis_tvalid(tvalid_s && (sel == 2'd2)), .s_axis_tready(tready[2]),
        .s_axis_tlast(tlast),
        .f_null(fo[2][0]), .f_n(fo[2][1]), .f_ne(fo[2][2]), .f_e(fo[2][3]),
        .f_se(fo[2][4]), .f_s(fo[2][5]), .f_sw(fo[2][6]), .f_w(fo[2][7]),
        .f_nw(fo[2][8]), .node_valid(nvalid[2]),
        .node_ready(nready_s && (sel == 2'd2)), .node_idx(idx[2]),
        .frame_done(fdone[2]), .tlast_err(terr[2]), .dbg_state(dbg[2])
    );

    // Outputs of the currently selected DUT.
    logic        c_ready, c_valid, c_fdone, c_err;
    logic [15:0] c_idx;
    logic [15:0] c_f [9];
    always_comb begin
        c_ready = tready[sel];
        c_valid = nvalid[sel];
        c_fdone = fdone[sel];
        c_err   = terr[sel];
        c_idx   = idx[sel];
        for (int i = 0; i < 9; i++) c_f[i] = fo[sel][i];
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [160:0] act, input logic [160:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [143:0] pack_f();
        logic [143:0] r;
        for (int i = 0; i < 9; i++) r[143-16*i -: 16] = c_f[i];
        return r;
    endfunction

    // Expected node: words base, base+1, ... base+8 in direction order.
    function automatic logic [160:0] mk(input logic [15:0] base, input logic [15:0] id,
                                        input logic fd);
        logic [143:0] r;
        for (int i = 0; i < 9; i++) r[143-16*i -: 16] = base + 16'(i);
        return {r, id, fd};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] d, input logic l);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        tdata    = d;
        tlast    = l;
        tvalid_s = 1'b1;
        while (!acc && n < 100) begin
            @(negedge aclk);
            acc = c_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        tvalid_s = 1'b0;
        tlast    = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout word=%h act=no_accept exp=accept", d);
        end
    endtask

    task automatic send_node(input logic [15:0] base, input logic last_flag, input bit gap);
        for (int i = 0; i < 9; i++) begin
            send(base + 16'(i), last_flag && (i == 8));
            if (gap && i < 8) tick();
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || c_valid) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout act=pending%0d exp=0", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge aclk) begin
        if (aresetn) begin
            if (c_valid && nready_s) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_handoff act=%h exp=none",
                             {pack_f(), c_idx, c_fdone});
                end else begin
                    chk("handoff", {pack_f(), c_idx, c_fdone}, exp_q.pop_front());
                end
            end else begin
                chk("frame_done_idle", 161'(c_fdone), 161'(0));
            end
            if (c_valid) chk("tready_in_hold", 161'(c_ready), 161'(0));
        end
    end

    // ---------------- stimulus ----------------
    logic [143:0] rec;
    initial begin
        aresetn  = 1'b0;
        tdata    = 16'd0;
        tvalid_s = 1'b0;
        tlast    = 1'b0;
        nready_s = 1'b0;
        sel      = 2'd0;

        // Reset values before any clock edge.
        #2;
        chk("rst_tready", 161'(c_ready), 161'(0));
        chk("rst_valid", 161'(c_valid), 161'(0));
        chk("rst_f", 161'(pack_f()), 161'(0));
        chk("rst_idx", 161'(c_idx), 161'(0));
        chk("rst_err", 161'(c_err), 161'(0));
        tick();
        tick();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("tready_before_edge", 161'(c_ready), 161'(0));
        tick();
        chk("tready_after_edge", 161'(c_ready), 161'(1));

        // Single node, N=1, back-to-back.
        nready_s = 1'b1;
        exp_q.push_back(mk(16'h0001, 16'd0, 1'b1));
        send_node(16'h0001, 1'b1, 1'b0);
        chk("valid_latency_t1", 161'(c_valid), 161'(1));
        wait_drain();
        chk("err_t1", 161'(c_err), 161'(0));

        // Backpressure for 20 cycles, junk on the stream meanwhile.
        nready_s = 1'b0;
        exp_q.push_back(mk(16'h0010, 16'd0, 1'b1));
        send_node(16'h0010, 1'b1, 1'b0);
        chk("valid_latency_bp", 161'(c_valid), 161'(1));
        rec      = pack_f();
        tvalid_s = 1'b1;
        tdata    = 16'hdead;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_f_stable", 161'(pack_f()), 161'(rec));
            chk("bp_tready", 161'(c_ready), 161'(0));
            chk("bp_valid", 161'(c_valid), 161'(1));
        end
        tvalid_s = 1'b0;
        nready_s = 1'b1;
        wait_drain();

        // Valid gaps between words.
        exp_q.push_back(mk(16'h0021, 16'd0, 1'b1));
        send_node(16'h0021, 1'b1, 1'b1);
        chk("valid_latency_gap", 161'(c_valid), 161'(1));
        wait_drain();
        chk("err_gap", 161'(c_err), 161'(0));

        // Reset during HOLD: pending node is discarded.
        nready_s = 1'b0;
        send_node(16'h0050, 1'b1, 1'b0);
        chk("valid_before_rst", 161'(c_valid), 161'(1));
        aresetn = 1'b0;
        #1;
        chk("rst_hold_valid", 161'(c_valid), 161'(0));
        chk("rst_hold_f", 161'(pack_f()), 161'(0));
        chk("rst_hold_idx", 161'(c_idx), 161'(0));
        tick();
        aresetn = 1'b1;
        tick();
        nready_s = 1'b1;
        exp_q.push_back(mk(16'h0060, 16'd0, 1'b1));
        send_node(16'h0060, 1'b1, 1'b0);
        wait_drain();

        // Early tlast, N=4: tlast on the 4th word of node 0.
        sel = 2'd1;
        tick();
        send(16'h0a00, 1'b0);
        send(16'h0a01, 1'b0);
        send(16'h0a02, 1'b0);
        send(16'h0a03, 1'b1);
        tick();
        chk("early_err", 161'(c_err), 161'(1));
        chk("early_valid", 161'(c_valid), 161'(0));
        chk("early_idx", 161'(c_idx), 161'(0));
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(16'h0100 * 16'(k + 1), 16'(k), k == 3));
        end
        for (int k = 0; k < 4; k++) begin
            send_node(16'h0100 * 16'(k + 1), k == 3, 1'b0);
            chk("valid_latency_n4", 161'(c_valid), 161'(1));
        end
        wait_drain();
        chk("n4_idx_wrap", 161'(c_idx), 161'(0));

        // Missing tlast, N=2.
        sel = 2'd2;
        tick();
        chk("n2_err_clean", 161'(c_err), 161'(0));
        exp_q.push_back(mk(16'h0b00, 16'd0, 1'b0));
        exp_q.push_back(mk(16'h0c00, 16'd1, 1'b1));
        send_node(16'h0b00, 1'b0, 1'b0);
        send_node(16'h0c00, 1'b0, 1'b0);
        wait_drain();
        chk("missing_err", 161'(c_err), 161'(1));
        chk("missing_idx_wrap", 161'(c_idx), 161'(0));

        tick();
        chk("queue_empty", 161'(exp_q.size()), 161'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
